// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM states
// and the multi-step mode classifier.
package shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROTL = 3'b100;
  localparam mode_t MODE_ROTR = 3'b101;
  localparam mode_t MODE_ASHR = 3'b110;
  localparam mode_t MODE_RSV  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only true shift/rotate modes make a multi-step run worth entering.
  function automatic logic is_multi_step(mode_t m);
    return !(m == MODE_HOLD || m == MODE_LOAD || m == MODE_RSV);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: next register value and shifted-out bit
// for a given mode. Load is resolved by the caller since it needs parallel data.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             sin,
  output logic [WIDTH-1:0] next_q,
  output logic             sout
);

  always_comb begin
    next_q = q;
    sout   = 1'b0;
    case (mode)
      MODE_SHL: begin
        next_q = {q[WIDTH-2:0], sin};
        sout   = q[WIDTH-1];
      end
      MODE_SHR: begin
        next_q = {sin, q[WIDTH-1:1]};
        sout   = q[0];
      end
      MODE_ROTL: begin
        next_q = {q[WIDTH-2:0], q[WIDTH-1]};
        sout   = q[WIDTH-1];
      end
      MODE_ROTR: begin
        next_q = {q[0], q[WIDTH-1:1]};
        sout   = q[0];
      end
      MODE_ASHR: begin
        next_q = {q[WIDTH-1], q[WIDTH-1:1]};
        sout   = q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with parallel load, shift/rotate/arithmetic modes
// and a stallable multi-step shift engine reporting busy/done.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  parameter int unsigned      CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_t            mode_q, mode_d;
  mode_t            eff_mode;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] amt_clamp;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] step_q;
  logic             done_q, done_d;

  // While running, the latched mode drives both the shifter and sout.
  assign eff_mode  = (state_q == ST_RUN) ? mode_q : mode;
  assign amt_clamp = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .q     (q_q),
    .mode  (eff_mode),
    .sin   (sin),
    .next_q(step_q),
    .sout  (sout)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (!preset) begin
      q_d     = PRESET_VAL;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d = mode;
            if (amt_clamp == '0 || !is_multi_step(mode)) begin
              cnt_d  = '0;
              done_d = 1'b1;
            end else begin
              cnt_d   = amt_clamp;
              state_d = ST_RUN;
            end
          end else if (en) begin
            q_d = (mode == MODE_LOAD) ? d : step_q;
          end
        end
        ST_RUN: begin
          if (en) begin
            q_d   = step_q;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ (WIDTH=8): behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_shift_reg_univ;

  logic       clk, reset, preset, en, sin, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] amount;
  logic [7:0] q;
  logic       sout, busy, done;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  shift_reg_univ dut (
    .clk   (clk),
    .reset (reset),
    .preset(preset),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .start (start),
    .amount(amount),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic view of one step of a mode.
  function automatic logic [7:0] apply(int unsigned v, int unsigned m, int unsigned s,
                                       int unsigned dd);
    int unsigned r;
    case (m)
      1:       r = dd;
      2:       r = (v * 2 + s) % 256;
      3:       r = v / 2 + s * 128;
      4:       r = (v * 2) % 256 + v / 128;
      5:       r = v / 2 + (v % 2) * 128;
      6:       r = v / 2 + (v / 128) * 128;
      default: r = v;
    endcase
    return r[7:0];
  endfunction

  // Reference model
  logic [7:0] mq;
  logic       mrun, mdone;
  int         mmode, mleft;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq = 0; mrun = 0; mdone = 0; mmode = 0; mleft = 0;
    end else begin
      logic nd;
      nd = 0;
      if (!preset) begin
        mq = 8'hFF; mrun = 0; mleft = 0;
      end else if (mrun) begin
        if (en) begin
          mq = apply(mq, mmode, sin, d);
          mleft = mleft - 1;
          if (mleft == 0) begin mrun = 0; nd = 1; end
        end
      end else if (start) begin
        mmode = mode;
        mleft = (amount > 8) ? 8 : amount;
        if (mleft == 0 || mode == 0 || mode == 1 || mode == 7) nd = 1;
        else mrun = 1;
      end else if (en) begin
        mq = apply(mq, mode, sin, d);
      end
      mdone = nd;
    end
  end

  function automatic logic model_sout();
    int em;
    em = mrun ? mmode : int'(mode);
    if (em == 2 || em == 4) return mq[7];
    if (em == 3 || em == 5 || em == 6) return mq[0];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_q", q, mq);
      chk("cmp_busy", busy, mrun);
      chk("cmp_done", done, mdone);
      chk("cmp_sout", sout, model_sout());
      chk("cmp_busy_done_exclusive", busy & done, 0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Literal check on both the DUT and the model.
  task automatic lit_q(string name, logic [7:0] exp);
    chk(name, q, exp);
    chk({name, "_model"}, mq, exp);
  endtask

  task automatic idle_in();
    preset = 1; en = 0; start = 0; mode = 0; sin = 0; d = 0; amount = 0;
  endtask

  task automatic load(logic [7:0] v);
    en = 1; start = 0; mode = 3'b001; d = v;
    tick();
    en = 0; mode = 0;
  endtask

  int done_at;

  initial begin
    reset = 0;
    idle_in();
    tick();
    tick();
    chk("reset_q", q, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1;
    cmp_on = 1;

    // Reset mid-cycle, then preset
    load(8'h5A);
    lit_q("load_5a", 8'h5A);
    #2 reset = 0;
    #1;
    chk("async_reset_q", q, 0);
    chk("async_reset_busy", busy, 0);
    tick();
    reset = 1;
    preset = 0;
    tick();
    lit_q("preset_ff", 8'hFF);
    preset = 1;

    // Load and single steps
    load(8'hB4);
    lit_q("load_b4", 8'hB4);
    en = 1; mode = 3'b010; sin = 1;
    tick();
    lit_q("shl_69", 8'h69);
    mode = 3'b110; sin = 0;
    tick();
    lit_q("ashr_34", 8'h34);
    mode = 3'b101;
    tick();
    lit_q("rotr_1a", 8'h1A);
    chk("rotr_sout", sout, 0);
    idle_in();

    // Multi-step rotl x3
    load(8'h81);
    start = 1; mode = 3'b100; amount = 3; en = 1;
    tick();
    chk("ms_busy_e0", busy, 1);
    lit_q("ms_q_e0", 8'h81);
    start = 0; mode = 0; amount = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("ms_busy", busy, (k < 3) ? 1 : 0);
      chk("ms_done", done, (k == 3) ? 1 : 0);
    end
    lit_q("ms_rotl_0c", 8'h0C);
    tick();
    chk("ms_done_one_cycle", done, 0);

    // Stall and clamp
    load(8'hFF);
    en = 1; start = 1; mode = 3'b011; sin = 0; amount = 12;
    tick();
    start = 0; mode = 0;
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      en = (k == 4 || k == 5) ? 0 : 1;
      tick();
      if (done) begin done_at = k; break; end
    end
    chk("clamp_done_edge", done_at, 10);
    lit_q("clamp_q_00", 8'h00);
    idle_in();

    // Abort by preset, start while busy ignored
    load(8'h0F);
    en = 1; start = 1; mode = 3'b010; sin = 0; amount = 5;
    tick();
    start = 0; mode = 0;
    tick();
    tick();
    start = 1; mode = 3'b101; amount = 1;
    tick();
    chk("abort_busy_step3", busy, 1);
    lit_q("abort_q_78", 8'h78);
    start = 1; preset = 0;
    tick();
    lit_q("abort_preset_ff", 8'hFF);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    idle_in();
    tick();
    chk("abort_no_done_late", done, 0);
    chk("abort_idle", busy, 0);

    // Degenerate starts
    en = 1; start = 1; mode = 3'b010; amount = 0;
    tick();
    chk("deg0_done", done, 1);
    chk("deg0_busy", busy, 0);
    lit_q("deg0_q", 8'hFF);
    start = 0; en = 0; mode = 0;
    tick();
    chk("deg0_done_clear", done, 0);
    en = 1; start = 1; mode = 3'b001; d = 8'h00; amount = 3;
    tick();
    chk("degld_done", done, 1);
    chk("degld_busy", busy, 0);
    lit_q("degld_q", 8'hFF);
    idle_in();
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      preset = ($urandom_range(0, 24) != 0);
      en     = ($urandom_range(0, 3) != 0);
      start  = ($urandom_range(0, 7) == 0);
      mode   = 3'($urandom_range(0, 7));
      sin    = 1'($urandom_range(0, 1));
      d      = 8'($urandom_range(0, 255));
      amount = 4'($urandom_range(0, 15));
      if (i == 300) begin
        #2 reset = 0;
        #1;
        chk("rand_async_reset_q", q, 0);
        tick();
        reset = 1;
      end else begin
        tick();
      end
    end

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
